// File: rtl/lane_perm_if.sv
// Bundled NOC-side input and consumer-side output handshakes of lane_perm.
// Both directions use the same rule: a word moves on a rising edge where the
// sender's push is 1 and the receiver's stop is 0. The sender holds its word
// while stop is 1.
interface lane_perm_if;
  logic        pushin;
  logic        firstin;
  logic [63:0] din;
  logic        stopin;
  logic        pushout;
  logic        firstout;
  logic [63:0] dout;
  logic        stopout;

  modport slave (
    input  pushin, firstin, din, stopout,
    output stopin, pushout, firstout, dout
  );

  modport master (
    output pushin, firstin, din, stopout,
    input  stopin, pushout, firstout, dout
  );
endinterface

// File: rtl/lane_perm.sv
// Collects a 25-word frame, waits 24 cycles, then emits each lane rotated
// left by its own lane index.
module lane_perm (
  input  logic         clk,
  input  logic         rst,
  lane_perm_if.slave   bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    BUSY   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  in_idx_q;
  logic [4:0]  out_idx_q;
  logic [4:0]  busy_cnt_q;
  logic [63:0] lane_q [25];

  logic        accept;
  logic        lane_we;
  logic [4:0]  lane_waddr;
  logic [63:0] rd_lane;
  logic [6:0]  rot_amt;
  logic [63:0] rot_lane;

  assign accept     = (state_q == LOAD) && bus.pushin;
  // A non-first word arriving with in_idx=0 has no frame to belong to.
  assign lane_we    = accept && (bus.firstin || (in_idx_q != 5'd0));
  assign lane_waddr = bus.firstin ? 5'd0 : in_idx_q;

  always_ff @(posedge clk) begin
    if (lane_we) begin
      lane_q[lane_waddr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      in_idx_q   <= 5'd0;
      out_idx_q  <= 5'd0;
      busy_cnt_q <= 5'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (bus.firstin) begin
              in_idx_q <= 5'd1;
            end else if (in_idx_q != 5'd0) begin
              if (in_idx_q == 5'd24) begin
                state_q    <= BUSY;
                in_idx_q   <= 5'd0;
                busy_cnt_q <= 5'd0;
              end else begin
                in_idx_q <= in_idx_q + 5'd1;
              end
            end
          end
        end
        BUSY: begin
          busy_cnt_q <= busy_cnt_q + 5'd1;
          if (busy_cnt_q == 5'd23) begin
            state_q <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (!bus.stopout) begin
            if (out_idx_q == 5'd24) begin
              out_idx_q <= 5'd0;
              state_q   <= LOAD;
            end else begin
              out_idx_q <= out_idx_q + 5'd1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // A shift by 64 yields zero, so out_idx=0 passes the lane through unchanged.
  assign rd_lane  = lane_q[out_idx_q];
  assign rot_amt  = {2'b00, out_idx_q};
  assign rot_lane = (rd_lane << rot_amt) | (rd_lane >> (7'd64 - rot_amt));

  assign bus.stopin   = (state_q != LOAD);
  assign bus.pushout  = (state_q == UNLOAD);
  assign bus.firstout = (state_q == UNLOAD) && (out_idx_q == 5'd0);
  assign bus.dout     = (state_q == UNLOAD) ? rot_lane : 64'd0;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lane_perm.sv
// Self-checking bench for lane_perm: table-driven frame plus directed
// stall, restart, noise, reset and back-to-back sequences.
module tb_lane_perm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  lane_perm_if bus ();

  lane_perm dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t        tbl [25];
  logic [63:0] fr [25];
  logic [64:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  logic        rand_stall = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_dout = 64'd0;
  logic        prev_first = 1'b0;
  logic [63:0] last_dout = 64'd0;

  function automatic logic [63:0] ref_rotl(input logic [63:0] x, input int s);
    logic [63:0] r;
    r = 64'd0;
    for (int b = 0; b < 64; b++) r[(b + s) % 64] = x[b];
    return r;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- consumer stall driver ----------------
  always @(negedge clk) begin
    if (rand_stall) bus.stopout = ($urandom_range(0, 3) == 0);
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else if (bus.pushout) begin
      if (prev_stall) begin
        chk("hold_dout", {1'b0, bus.dout}, {1'b0, prev_dout});
        chk("hold_first", {64'd0, bus.firstout}, {64'd0, prev_first});
      end
      if (!bus.stopout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {bus.firstout, bus.dout}, 65'd0);
        end else begin
          chk("out_word", {bus.firstout, bus.dout}, exp_q.pop_front());
          hs_cnt++;
          last_dout = bus.dout;
        end
      end
      prev_stall = bus.stopout;
      prev_dout  = bus.dout;
      prev_first = bus.firstout;
    end else begin
      chk("idle_zero", {bus.firstout, bus.dout}, 65'd0);
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [63:0] d, input logic f);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.pushin  = 1'b1;
    bus.din     = d;
    bus.firstin = f;
    while (bus.stopin && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("send_timeout", 65'(guard), 65'd0);
  endtask

  task automatic send_frame(input logic push_exp);
    for (int i = 0; i < 25; i++) send_word(fr[i], (i == 0));
    if (push_exp) begin
      for (int i = 0; i < 25; i++) exp_q.push_back({(i == 0), ref_rotl(fr[i], i)});
    end
  endtask

  task automatic wait_pushout();
    int guard;
    guard = 0;
    @(negedge clk);
    bus.pushin = 1'b0;
    while (!bus.pushout && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("pushout_timeout", 65'(guard), 65'd0);
  endtask

  task automatic wait_drain(input logic noise);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.pushout) && guard < 1000) begin
      if (noise) begin
        bus.pushin  = ($urandom_range(0, 1) == 1);
        bus.firstin = ($urandom_range(0, 1) == 1);
        bus.din     = {$urandom, $urandom};
      end else begin
        bus.pushin = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.pushin = 1'b0;
    if (guard >= 1000) chk("drain_timeout", 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int hs0;

    for (int i = 0; i < 25; i++) begin
      tbl[i].din  = 64'(i + 1);
      tbl[i].dout = ref_rotl(64'(i + 1), i);
    end

    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.din     = 64'd0;
    bus.stopout = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stopin", {64'd0, bus.stopin}, 65'd0);
    chk("rst_pushout", {64'd0, bus.pushout}, 65'd0);
    chk("rst_firstout", {64'd0, bus.firstout}, 65'd0);
    chk("rst_dout", {1'b0, bus.dout}, 65'd0);
    chk("rst_state", {63'd0, dbg_state}, 65'd0);
    rst = 1'b0;

    // Scenario 1: table frame, no stalls, latency and endpoints.
    hs0 = hs_cnt;
    for (int i = 0; i < 25; i++) begin
      send_word(tbl[i].din, (i == 0));
      exp_q.push_back({(i == 0), tbl[i].dout});
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.pushin = 1'b0;
        chk("s1_stopin_busy", {64'd0, bus.stopin}, 65'd1);
      end
    end while (!bus.pushout && lat < 100);
    chk("s1_latency", 65'(lat), 65'd25);
    chk("s1_first_dout", {bus.firstout, bus.dout}, {1'b1, 64'h1});
    wait_drain(1'b0);
    chk("s1_last_dout", {1'b0, last_dout}, {1'b0, 64'h1900_0000});
    chk("s1_count", 65'(hs_cnt - hs0), 65'd25);
    chk("s1_stopin_load", {64'd0, bus.stopin}, 65'd0);

    // Scenario 2: 5-cycle stall at out_idx=3.
    hs0 = hs_cnt;
    for (int i = 0; i < 25; i++) fr[i] = tbl[i].din;
    send_frame(1'b1);
    wait_pushout();
    repeat (3) @(negedge clk);
    bus.stopout = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("s2_stall_dout", {1'b0, bus.dout}, {1'b0, 64'h20});
      chk("s2_stall_push", {64'd0, bus.pushout}, 65'd1);
      @(negedge clk);
    end
    bus.stopout = 1'b0;
    chk("s2_release_dout", {1'b0, bus.dout}, {1'b0, 64'h20});
    wait_drain(1'b0);
    chk("s2_count", 65'(hs_cnt - hs0), 65'd25);

    // Scenario 3: restart after 10 words, random consumer stalls.
    hs0 = hs_cnt;
    rand_stall = 1'b1;
    for (int i = 0; i < 10; i++) send_word(64'h1000 + 64'(i), (i == 0));
    fr[0] = 64'hAAAA;
    for (int i = 1; i < 25; i++) fr[i] = 64'h2000 + 64'(i);
    send_frame(1'b1);
    wait_drain(1'b0);
    rand_stall  = 1'b0;
    bus.stopout = 1'b0;
    chk("s3_count", 65'(hs_cnt - hs0), 65'd25);

    // Scenario 4: orphan word at in_idx=0, then noise during BUSY/UNLOAD.
    hs0 = hs_cnt;
    send_word(64'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 25; i++) fr[i] = tbl[i].din;
    for (int i = 1; i < 25; i++) send_word(fr[i - 1] * 0 + 64'hBAD0, 1'b0);
    send_frame(1'b1);
    wait_drain(1'b1);
    chk("s4_count", 65'(hs_cnt - hs0), 65'd25);
    chk("s4_last_dout", {1'b0, last_dout}, {1'b0, 64'h1900_0000});

    // Scenario 5a: reset during BUSY at busy_cnt=10.
    send_frame(1'b0);
    @(negedge clk);
    bus.pushin = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5a_stopin", {64'd0, bus.stopin}, 65'd0);
    chk("s5a_pushout", {64'd0, bus.pushout}, 65'd0);
    chk("s5a_dout", {1'b0, bus.dout}, 65'd0);
    repeat (40) @(negedge clk);
    chk("s5a_no_output", 65'(exp_q.size()), 65'd0);

    // Scenario 5b: reset during UNLOAD at out_idx=7.
    send_frame(1'b1);
    wait_pushout();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("s5b_stopin", {64'd0, bus.stopin}, 65'd0);
    chk("s5b_pushout", {64'd0, bus.pushout}, 65'd0);
    chk("s5b_dout", {1'b0, bus.dout}, 65'd0);
    hs0 = hs_cnt;
    for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
    send_frame(1'b1);
    wait_drain(1'b0);
    chk("s5_recover_count", 65'(hs_cnt - hs0), 65'd25);

    // Scenario 6: back-to-back frames, second first word held until LOAD.
    hs0 = hs_cnt;
    rand_stall = 1'b1;
    for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
    send_frame(1'b1);
    for (int i = 0; i < 25; i++) fr[i] = {$urandom, $urandom};
    send_frame(1'b1);
    wait_drain(1'b0);
    rand_stall  = 1'b0;
    bus.stopout = 1'b0;
    chk("s6_count", 65'(hs_cnt - hs0), 65'd50);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
